// File: rtl/npc_pkg.sv
// Shared constants and types for the next-PC / fetch unit.
// Imported by the prefetcher and its instruction FIFO.
package npc_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FAULT
  } fetch_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction FIFO with flush and same-cycle push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo
  import npc_pkg::*;
#(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push &&
    ((cnt_q != (AW+1)'(DEPTH)) || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch unit: owns the PC, issues one fetch at a time and
// buffers responses for decode; handles redirect, fault, halt.
module ifu_prefetch #(
  parameter int              XLEN     = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [XLEN-1:0]          mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [npc_pkg::ILEN-1:0] mem_rsp_data,
  input  logic                     mem_rsp_err,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [npc_pkg::ILEN-1:0] inst,
  output logic [XLEN-1:0]          inst_pc,
  output logic                     inst_err,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     halt,
  output logic                     busy
);

  import npc_pkg::*;

  localparam int FW = 1 + XLEN + ILEN;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            discard_q, discard_d;
  logic            push, pop, accept, rsp_live;
  logic [CW-1:0]   count, cnt_next;
  logic [FW-1:0]   head;

  assign accept   = req_q & mem_req_ready;
  assign rsp_live = mem_rsp_valid & (state_q == S_WAIT);
  assign pop      = inst_valid & inst_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    req_d     = req_q;
    discard_d = discard_q;
    push      = 1'b0;
    if (accept) begin
      req_d   = 1'b0;
      state_d = S_WAIT;
    end
    if (rsp_live) begin
      discard_d = 1'b0;
      state_d   = S_REQ;
      if (!discard_q && !redirect_valid) begin
        push = 1'b1;
        pc_d = pc_q + XLEN'(4);
        if (mem_rsp_err) state_d = S_FAULT;
      end
    end
    // Anything still outstanding after this edge is stale.
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
      if (state_q == S_FAULT) state_d = S_REQ;
      discard_d = req_q ||
        ((state_q == S_WAIT) && !mem_rsp_valid);
    end
    cnt_next = redirect_valid ? '0 :
      count + CW'(push) - CW'(pop);
    if (!req_d && state_d == S_REQ && !halt &&
        cnt_next < CW'(DEPTH)) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      discard_q <= discard_d;
    end
  end

  ifu_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   ({mem_rsp_err, pc_q, mem_rsp_data}),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign mem_req_valid = req_q;
  assign mem_req_addr  = addr_q;
  assign busy          = (state_q == S_WAIT);
  assign inst_valid    = (count != '0);
  assign inst_err      = head[FW-1];
  assign inst_pc       = head[FW-2 -: XLEN];
  assign inst          = head[ILEN-1:0];

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised successor to the single-cycle core's PC register and fetch path.
- Owns the PC and fetches instructions over a valid/ready memory request/response interface, one fetch outstanding at a time.
- Buffers fetched instructions in a DEPTH-entry FIFO and hands them to decode with a valid/ready handshake.
- Sits between the memory arbiter and the IDU; supports branch/jump redirect with flush, fault reporting and halt drain.

Parameters:
XLEN, 32, width of PC and address bus
RESET_PC, 32'h8000_0000, PC loaded on reset
DEPTH, 4, instruction FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  fetch address, word aligned
mem_rsp_valid  in  1  fetch response valid (always accepted)
mem_rsp_data  in  32  fetched instruction
mem_rsp_err  in  1  access fault on this response
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decode consumes head
inst  out  32  head instruction
inst_pc  out  XLEN  head PC
inst_err  out  1  head carries access fault
redirect_valid  in  1  control-flow redirect
redirect_pc  in  XLEN  redirect target; bits [1:0] are forced to 0
halt  in  1  level; stop issuing new fetches
busy  out  1  a fetch is in flight

Behaviour:
- Interface conventions: reset rst, synchronous, active-high; clock clk. All outputs are registered or derived from registered state only.
- Reset values: pc=RESET_PC; FIFO empty; state=S_REQ; discard=0; mem_req_valid=0, inst_valid=0, busy=0 while rst is high.
- States:
  - S_REQ: mem_req_valid=1 when credit is available (count < DEPTH) and halt=0.
  - S_WAIT: request accepted; awaiting response; busy=1.
  - S_FAULT: error received; no further fetches.
- Transitions:
  - S_REQ->S_WAIT on mem_req_valid & mem_req_ready.
  - S_WAIT->S_REQ on mem_rsp_valid with err=0.
  - S_WAIT->S_FAULT on mem_rsp_valid & err, if not discarded.
  - S_FAULT->S_REQ on redirect.
- Request rules:
  - mem_req_addr=pc; address is held stable while valid & !ready.
  - Once asserted, valid is not withdrawn until accepted, even on redirect or halt.
- Response handling (not discarded):
  - Push {err, pc, data} into the FIFO; pc += 4 (wraps mod 2^XLEN).
  - Head is visible on inst_* the cycle after the response.
  - Next request is issued the cycle after the response (S_WAIT->S_REQ).
- Credit: count counts occupied entries. Because only one fetch is in flight, an overflowing push is impossible.
- Consume: the head is popped on inst_valid & inst_ready. A push and a pop in the same cycle leave the count unchanged.
- Redirect (takes priority over everything else, same cycle):
  - Flush the FIFO, so inst_valid=0 the next cycle.
  - Set pc=redirect_pc & ~3.
  - If a fetch is in flight or the request is pending unaccepted, set discard=1.
  - A handshake on inst in the same cycle counts as consumed.
  - A redirect coinciding with mem_rsp_valid discards that response.
- Discard handling:
  - While discard=1, the next response is dropped (its err is ignored too) and discard is cleared.
  - A pending unaccepted request, once accepted, is treated as in flight. Its response is dropped, then the core fetches redirect_pc.
- Halt: no new request is raised while halt=1. An in-flight fetch completes normally; busy falls after its response.
- Reset mid-operation: returns to reset values immediately. Any response arriving after rst deasserts and before the first new request is ignored.

Decomposition:
- Package npc_pkg holds XLEN, RESET_PC default, the fetch state enum (S_REQ, S_WAIT, S_FAULT) and the instruction-width constant ILEN=32.
- One sub-module, ifu_fifo: synchronous FIFO, width 1+XLEN+32, depth DEPTH, with a flush input, count output, and same-cycle push/pop support.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle response latency, inst_ready=1 -> requests to 0x80000000, 0x80000004, 0x80000008 in order; inst_pc matches each, and inst_valid rises one cycle after each response.
- inst_ready=0 with 5 responses available -> exactly 4 accepted (count=DEPTH=4) and mem_req_valid=0 afterwards; one pop -> a request to 0x80000010 is issued the next cycle.
- Redirect to 0x80000103 while in S_WAIT, response data 0xDEADBEEF -> the response is dropped, the FIFO is flushed, and the next request goes to 0x80000100.
- Redirect while mem_req_ready=0 holds a request to 0x80000008 -> addr stays 0x80000008 until accepted, its response is dropped, then a request to the redirect target follows.
- mem_rsp_err=1 on the fetch at 0x80000004 -> an entry with inst_err=1, inst_pc=0x80000004 is presented and no further requests issue; redirect to 0x80000200 resumes fetching.
- halt=1 raised during S_WAIT -> the response is buffered, busy drops, and no new request issues until halt=0. Also: rst asserted mid-fetch -> inst_valid=0 and the next request goes to 0x80000000.
